// File: rtl/seg7_scan_driver.sv
// ---------------------------------------------------------------------------
// seg7_scan_driver
//
// Time-multiplexed driver for a bank of common-anode seven-segment digits.
// Each digit gets a slot of CLK_DIV clocks. Digits are scanned from 0 up to
// NUM_DIGITS-1 and then the scan starts again. The display data and masks
// are sampled once per frame, at the end of the last slot, so that a value
// that changes mid-scan never shows as a torn mix of old and new digits.
// Brightness is a 16-level PWM applied inside each slot.
//
// Parameters:
//   NUM_DIGITS  number of digits scanned (1..8)
//   CLK_DIV     clk_16M cycles per digit slot (>= 16)
//
// Ports:
//   clk_16M      in   system clock, rising edge
//   rst          in   synchronous active-high reset
//   data         in   packed hex nibbles, digit i = data[4i+3:4i]
//   digit_en     in   per-digit enable (1 = lit)
//   dp_mask      in   per-digit decimal point (1 = on)
//   bright       in   brightness, on-time = (bright+1)/16 of a slot
//   an           out  anode enables, active-low, at most one low
//   seg          out  segments {g,f,e,d,c,b,a}, active-low
//   dp           out  decimal point, active-low
//   frame_start  out  one-cycle pulse when the digit 0 slot appears on an
//
// Optional build macro:
//   SEG7_LEADING_ZERO_BLANK_EN  blank leading zero digits (digit 0 is
//                               always shown)
// ---------------------------------------------------------------------------
module seg7_scan_driver #(
  parameter int NUM_DIGITS = 4,
  parameter int CLK_DIV    = 48000
) (
  input  logic                    clk_16M,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] data,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  input  logic [NUM_DIGITS-1:0]   dp_mask,
  input  logic [3:0]              bright,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic                    frame_start
);

  localparam int CW = $clog2(CLK_DIV);
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  // cnt*16 needs CW+4 bits and CLK_DIV*16 needs at most CW+5 bits.
  localparam int PW = CW + 5;

  localparam logic [CW-1:0] CNT_MAX = CW'(CLK_DIV - 1);
  localparam logic [IW-1:0] IDX_MAX = IW'(NUM_DIGITS - 1);

  // Scan position
  logic [CW-1:0] cnt_q, cnt_d;
  logic [IW-1:0] idx_q, idx_d;

  // Frame-latched display state
  logic [4*NUM_DIGITS-1:0] data_q;
  logic [NUM_DIGITS-1:0]   en_q;
  logic [NUM_DIGITS-1:0]   dp_q;
  logic [3:0]              bright_q;

  // Registered outputs
  logic [NUM_DIGITS-1:0] anOut_q, anOut_d;
  logic [6:0]            segOut_q, segOut_d;
  logic                  dpOut_q, dpOut_d;
  logic                  wrapSeen_q;
  logic                  frameStart_q;

  logic tick;
  logic wrap;

  logic [PW-1:0] pwmLhs;
  logic [PW-1:0] pwmRhs;
  logic [4:0]    brightPlus;
  logic          pwmOn;

  logic [NUM_DIGITS-1:0] litMask;
  logic [NUM_DIGITS-1:0] anOneHot;
  logic [3:0]            nib;
  logic                  digLit;
  logic                  digDp;
  logic [6:0]            segMap;

  // Slot counter and digit index. An out-of-range index (not reachable in
  // normal operation) is pulled back to digit 0 on the next tick.
  always_comb begin
    tick  = (cnt_q == CNT_MAX);
    wrap  = tick && (idx_q == IDX_MAX);
    cnt_d = tick ? '0 : cnt_q + CW'(1);
    idx_d = idx_q;
    if (tick) begin
      if (idx_q >= IDX_MAX) begin
        idx_d = '0;
      end else begin
        idx_d = idx_q + IW'(1);
      end
    end
  end

  // PWM compare. The blank at the last count of a slot guarantees an
  // all-high anode cycle between digits even at full brightness.
  always_comb begin
    brightPlus = {1'b0, bright_q} + 5'd1;
    pwmLhs     = PW'(cnt_q) << 4;
    pwmRhs     = PW'(CLK_DIV) * PW'(brightPlus);
    pwmOn      = (pwmLhs < pwmRhs) && !tick;
  end

`ifdef SEG7_LEADING_ZERO_BLANK_EN
  logic [NUM_DIGITS-1:0] lzBlank;
  logic                  zeroAbove;

  // Walk from the most significant digit down. A zero nibble is blanked
  // while every enabled digit above it is also zero; disabled digits do not
  // stop the blanking. Digit 0 is never considered, so "0" stays visible.
  always_comb begin
    lzBlank   = '0;
    zeroAbove = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      if (data_q[4*i +: 4] == 4'd0) begin
        lzBlank[i] = zeroAbove;
      end else if (en_q[i]) begin
        zeroAbove = 1'b0;
      end
    end
    litMask = en_q & ~lzBlank;
  end
`else
  always_comb begin
    litMask = en_q;
  end
`endif

  // Select the current digit's nibble, lit flag and DP bit. The loop form
  // keeps every index in range even if idx_q were ever out of bounds.
  always_comb begin
    nib      = '0;
    digLit   = 1'b0;
    digDp    = 1'b0;
    anOneHot = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_q == IW'(i)) begin
        nib         = data_q[4*i +: 4];
        digLit      = litMask[i];
        digDp       = dp_q[i];
        anOneHot[i] = 1'b1;
      end
    end
  end

  // Hex to active-low segment pattern {g,f,e,d,c,b,a}
  always_comb begin
    segMap = 7'b1111111;
    case (nib)
      4'h0: segMap = 7'b1000000;
      4'h1: segMap = 7'b1111001;
      4'h2: segMap = 7'b0100100;
      4'h3: segMap = 7'b0110000;
      4'h4: segMap = 7'b0011001;
      4'h5: segMap = 7'b0010010;
      4'h6: segMap = 7'b0000010;
      4'h7: segMap = 7'b1111000;
      4'h8: segMap = 7'b0000000;
      4'h9: segMap = 7'b0010000;
      4'hA: segMap = 7'b0001000;
      4'hB: segMap = 7'b0000011;
      4'hC: segMap = 7'b1000110;
      4'hD: segMap = 7'b0100001;
      4'hE: segMap = 7'b0000110;
      4'hF: segMap = 7'b0001110;
      default: segMap = 7'b1111111;
    endcase
  end

  // Next output values: either the current digit or fully blank
  always_comb begin
    anOut_d  = '1;
    segOut_d = 7'b1111111;
    dpOut_d  = 1'b1;
    if (pwmOn && digLit) begin
      anOut_d  = ~anOneHot;
      segOut_d = segMap;
      dpOut_d  = ~digDp;
    end
  end

  // State registers. wrapSeen_q delays the wrap by one cycle so that
  // frame_start lines up with the first output cycle of digit 0.
  always_ff @(posedge clk_16M) begin
    if (rst) begin
      cnt_q        <= '0;
      idx_q        <= '0;
      data_q       <= '0;
      en_q         <= '0;
      dp_q         <= '0;
      bright_q     <= '0;
      anOut_q      <= '1;
      segOut_q     <= 7'b1111111;
      dpOut_q      <= 1'b1;
      wrapSeen_q   <= 1'b0;
      frameStart_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      anOut_q      <= anOut_d;
      segOut_q     <= segOut_d;
      dpOut_q      <= dpOut_d;
      wrapSeen_q   <= wrap;
      frameStart_q <= wrapSeen_q;
      if (wrap) begin
        data_q   <= data;
        en_q     <= digit_en;
        dp_q     <= dp_mask;
        bright_q <= bright;
      end
    end
  end

  assign an          = anOut_q;
  assign seg         = segOut_q;
  assign dp          = dpOut_q;
  assign frame_start = frameStart_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// ---------------------------------------------------------------------------
// tb_seg7_scan_driver
//
// Directed bench for seg7_scan_driver with NUM_DIGITS=4 and CLK_DIV=16, so
// one frame is 64 clocks. Outputs are sampled on the falling edge. Expected
// values come from a hand-written segment table and the simple rule that a
// digit is lit at count c when c < bright+1 and c is not the last count.
// ---------------------------------------------------------------------------
module tb_seg7_scan_driver;

  localparam int ND = 4;
  localparam int CD = 16;

  logic        clock;
  logic        reset;
  logic [15:0] data;
  logic [3:0]  digitEn;
  logic [3:0]  dpMask;
  logic [3:0]  bright;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        frameStart;

  int total = 0;
  int bad   = 0;
  int skipped;

  logic [6:0] segTab [16];

  seg7_scan_driver #(
    .NUM_DIGITS(ND),
    .CLK_DIV(CD)
  ) dut (
    .clk_16M(clock),
    .rst(reset),
    .data(data),
    .digit_en(digitEn),
    .dp_mask(dpMask),
    .bright(bright),
    .an(an),
    .seg(seg),
    .dp(dp),
    .frame_start(frameStart)
  );

  // 10 ns clock
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Safety net in case something stalls the directed sequence
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, required finish before 200000 ns");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic applyStimulus(input logic [15:0] d, input logic [3:0] en,
                               input logic [3:0] dpm, input logic [3:0] br);
    data    = d;
    digitEn = en;
    dpMask  = dpm;
    bright  = br;
  endtask

  task automatic checkOutput(input string tag, input logic [3:0] expAn,
                             input logic [6:0] expSeg, input logic expDp,
                             input logic expFs);
    logic [12:0] obsVec;
    logic [12:0] expVec;
    obsVec = {an, seg, dp, frameStart};
    expVec = {expAn, expSeg, expDp, expFs};
    total++;
    assert (obsVec === expVec) else begin
      bad++;
      $error("[TB] FAIL %s: observed an=%b seg=%b dp=%b fs=%b, expected an=%b seg=%b dp=%b fs=%b",
             tag, an, seg, dp, frameStart, expAn, expSeg, expDp, expFs);
    end
  endtask

  // Wait for the next frame_start (bounded); reports the cycles waited
  task automatic waitFrame(input string tag, output int waited);
    bit found;
    waited = 0;
    found  = 1'b0;
    while (!found && waited < 200) begin
      @(negedge clock);
      waited++;
      if (frameStart === 1'b1) found = 1'b1;
    end
    if (!found) begin
      total++;
      bad++;
      $error("[TB] FAIL %s: frame_start not seen, observed none in %0d cycles, required one", tag, waited);
    end
  endtask

  task automatic checkBlank(input string tag, input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clock);
      checkOutput(tag, 4'hF, 7'b1111111, 1'b1, 1'b0);
    end
  endtask

  // Check one whole frame. If midJ >= 0, data is changed to midData at that
  // output cycle to show the change stays invisible until the next frame.
  task automatic checkFrame(input string tag, input logic [15:0] expData,
                            input logic [3:0] expEn, input logic [3:0] expDp,
                            input logic [3:0] expBright, input int midJ,
                            input logic [15:0] midData, input int expWait);
    int         waited;
    int         d;
    int         c;
    logic       lit;
    logic [3:0] nib;
    logic [3:0] expAn;
    logic [6:0] expSeg;
    logic       expDpBit;
    waitFrame(tag, waited);
    total++;
    assert (waited == expWait) else begin
      bad++;
      $error("[TB] FAIL %s period: observed %0d cycles to frame_start, expected %0d", tag, waited, expWait);
    end
    for (int j = 0; j < ND * CD; j++) begin
      if (j > 0) @(negedge clock);
      if (j == midJ) data = midData;
      d        = j / CD;
      c        = j % CD;
      nib      = expData[4*d +: 4];
      lit      = expEn[d] && (c < int'(expBright) + 1) && (c != CD - 1);
      expAn    = lit ? ~(4'b0001 << d) : 4'hF;
      expSeg   = lit ? segTab[nib] : 7'b1111111;
      expDpBit = lit ? ~expDp[d] : 1'b1;
      checkOutput(tag, expAn, expSeg, expDpBit, (j == 0));
    end
  endtask

  // Directed sequence
  initial begin
    segTab = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
               7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
               7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
               7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

    $display("[TB] reset and first scan");
    reset = 1'b1;
    applyStimulus(16'h1A3F, 4'hF, 4'h0, 4'hF);
    repeat (3) begin
      @(negedge clock);
      checkOutput("reset", 4'hF, 7'b1111111, 1'b1, 1'b0);
    end
    reset = 1'b0;
    checkBlank("frame1 blank", ND * CD);
    checkFrame("scan 1A3F", 16'h1A3F, 4'hF, 4'h0, 4'hF, -1, 16'h0, 1);
    checkFrame("scan 1A3F again", 16'h1A3F, 4'hF, 4'h0, 4'hF, -1, 16'h0, 1);

    $display("[TB] tear-free update");
    applyStimulus(16'h1234, 4'hF, 4'h0, 4'hF);
    waitFrame("skip", skipped);
    checkFrame("tear old", 16'h1234, 4'hF, 4'h0, 4'hF, 2 * CD + 4, 16'h5678, ND * CD);
    checkFrame("tear new", 16'h5678, 4'hF, 4'h0, 4'hF, -1, 16'h0, 1);

    $display("[TB] brightness");
    applyStimulus(16'h5678, 4'hF, 4'h0, 4'h3);
    waitFrame("skip", skipped);
    checkFrame("pwm b3", 16'h5678, 4'hF, 4'h0, 4'h3, -1, 16'h0, ND * CD);
    applyStimulus(16'h5678, 4'hF, 4'h0, 4'h0);
    waitFrame("skip", skipped);
    checkFrame("pwm b0", 16'h5678, 4'hF, 4'h0, 4'h0, -1, 16'h0, ND * CD);

    $display("[TB] digit and dp masks");
    applyStimulus(16'h5678, 4'b0101, 4'b0010, 4'hF);
    waitFrame("skip", skipped);
    checkFrame("mask dp1", 16'h5678, 4'b0101, 4'b0010, 4'hF, -1, 16'h0, ND * CD);
    applyStimulus(16'h5678, 4'b0101, 4'b0001, 4'hF);
    waitFrame("skip", skipped);
    checkFrame("mask dp0", 16'h5678, 4'b0101, 4'b0001, 4'hF, -1, 16'h0, ND * CD);

    $display("[TB] mid-frame reset");
    waitFrame("sync", skipped);
    repeat (2 * CD + 2) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    checkOutput("midreset", 4'hF, 7'b1111111, 1'b1, 1'b0);
    reset = 1'b0;
    checkBlank("post-reset blank", ND * CD);
    checkFrame("resume", 16'h5678, 4'b0101, 4'b0001, 4'hF, -1, 16'h0, 1);

`ifdef SEG7_LEADING_ZERO_BLANK_EN
    $display("[TB] leading zero blanking");
    applyStimulus(16'h0040, 4'hF, 4'h0, 4'hF);
    waitFrame("skip", skipped);
    checkFrame("lz 0040", 16'h0040, 4'b0011, 4'h0, 4'hF, -1, 16'h0, ND * CD);
    applyStimulus(16'h0000, 4'hF, 4'h0, 4'hF);
    waitFrame("skip", skipped);
    checkFrame("lz 0000", 16'h0000, 4'b0001, 4'h0, 4'hF, -1, 16'h0, ND * CD);
`else
    $display("[TB] leading zeros shown");
    applyStimulus(16'h0040, 4'hF, 4'h0, 4'hF);
    waitFrame("skip", skipped);
    checkFrame("zeros 0040", 16'h0040, 4'hF, 4'h0, 4'hF, -1, 16'h0, ND * CD);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
